seven_segment_scan_controller: RTL and testbench

//  Time-multiplexes one shared BCD-to-seven-segment decoder across NUM_DIGITS common-anode/cathode digits.

---
 rtl/seven_segment_scan_controller.sv | 209 ++++++++++++++++++++
 tb/tb_seven_segment_scan_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_controller.sv
// seven_segment_scan_controller
//   Drives several seven-segment digits from one shared BCD decoder by scanning
//   them one at a time. Each digit gets a blanking gap (anti-ghosting) and then
//   a dwell period. A shadow bank, loaded through a valid/ready handshake, is
//   copied into the displayed bank only at a frame boundary, so a new word never
//   appears half-drawn.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   load_valid     new display word offered
//   load_ready     shadow bank free; transfer on load_valid && load_ready
//   load_data      BCD nibbles, digit i = load_data[4i+3:4i], digit 0 least significant
//   lz_suppress_en 1: blank leading zeros (digit 0 always shows)
//   bcd_out        BCD code to the shared decoder
//   seg_blank      1: force all segments off downstream of the decoder
//   digit_en       one-hot digit select, active-low when DIGIT_ACTIVE_LOW=1
//   frame_done     one-cycle pulse at the start of each new scan frame
//   blink_mask     (SEVEN_SEG_BLINK_EN only) digits hidden during the blink-off phase
//
// Optional feature macro: SEVEN_SEG_BLINK_EN adds BLINK_FRAMES and blink_mask.
module seven_segment_scan_controller #(
  parameter int NUM_DIGITS       = 4,
  parameter int DWELL_CYCLES     = 1000,
  parameter int BLANK_CYCLES     = 16,
  parameter int DIGIT_ACTIVE_LOW = 1
`ifdef SEVEN_SEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES     = 64
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    lz_suppress_en,
`ifdef SEVEN_SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [3:0]              bcd_out,
  output logic                    seg_blank,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] EN_OFF = (DIGIT_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DWELL
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [IW-1:0]   idx, idx_n;
  logic [3:0]      disp   [NUM_DIGITS];
  logic [3:0]      disp_n [NUM_DIGITS];
  logic [3:0]      shadow [NUM_DIGITS];
  logic            pending, pending_n;
  logic            wrap, accept, do_commit;
  logic            hide_n;

  logic [3:0]            bcd_n;
  logic                  seg_blank_n;
  logic [NUM_DIGITS-1:0] digit_en_n;
  logic [3:0]            code;
  logic                  upper_zero, lz_hide, visible;

  // Scan sequencing
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    wrap    = 1'b0;
    case (state)
      ST_IDLE: begin
        state_n = ST_BLANK;
        cnt_n   = '0;
        idx_n   = '0;
      end
      ST_BLANK: begin
        if (cnt == CW'(BLANK_CYCLES - 1)) begin
          state_n = ST_DWELL;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_DWELL: begin
        if (cnt == CW'(DWELL_CYCLES - 1)) begin
          state_n = ST_BLANK;
          cnt_n   = '0;
          if (idx == IW'(NUM_DIGITS - 1)) begin
            idx_n = '0;
            wrap  = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Bank handshake. Commit looks at the old pending flag, so a word accepted on
  // the boundary cycle itself waits for the following frame boundary.
  always_comb begin
    accept    = load_valid && !pending;
    do_commit = ((state == ST_IDLE) || wrap) && pending;
    if (accept)         pending_n = 1'b1;
    else if (do_commit) pending_n = 1'b0;
    else                pending_n = pending;
    disp_n = disp;
    if (do_commit) disp_n = shadow;
  end

`ifdef SEVEN_SEG_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES) + 1;
  logic [NUM_DIGITS-1:0] mask_disp, mask_disp_n, mask_shadow;
  logic [FW-1:0]         fcnt, fcnt_n;
  logic                  phase_off, phase_off_n;

  always_comb begin
    mask_disp_n = do_commit ? mask_shadow : mask_disp;
    fcnt_n      = fcnt;
    phase_off_n = phase_off;
    if (wrap) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt_n      = '0;
        phase_off_n = !phase_off;
      end else begin
        fcnt_n = fcnt + 1'b1;
      end
    end
    hide_n = phase_off_n && mask_disp_n[idx_n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_disp   <= '0;
      mask_shadow <= '0;
      fcnt        <= '0;
      phase_off   <= 1'b0;
    end else begin
      if (accept) mask_shadow <= blink_mask;
      mask_disp <= mask_disp_n;
      fcnt      <= fcnt_n;
      phase_off <= phase_off_n;
    end
  end
`else
  assign hide_n = 1'b0;
`endif

  // Outputs are registered from next-state values so they line up with the
  // state they describe rather than lagging it by a cycle.
  always_comb begin
    code       = disp_n[idx_n];
    upper_zero = 1'b1;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if ((IW'(j) >= idx_n) && (disp_n[j] != 4'd0)) upper_zero = 1'b0;
    end
    lz_hide     = lz_suppress_en && (idx_n != '0) && upper_zero;
    visible     = (state_n == ST_DWELL) && (code <= 4'd9) && !lz_hide && !hide_n;
    bcd_n       = (state_n == ST_DWELL) ? code : bcd_out;
    seg_blank_n = !visible;
    digit_en_n  = visible ? ((NUM_DIGITS'(1) << idx_n) ^ EN_OFF) : EN_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      load_ready <= 1'b1;
      bcd_out    <= '0;
      seg_blank  <= 1'b1;
      digit_en   <= EN_OFF;
      frame_done <= 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        disp[i]   <= '0;
        shadow[i] <= '0;
      end
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      pending    <= pending_n;
      load_ready <= !pending_n;
      bcd_out    <= bcd_n;
      seg_blank  <= seg_blank_n;
      digit_en   <= digit_en_n;
      frame_done <= wrap;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        disp[i] <= disp_n[i];
        if (accept) shadow[i] <= load_data[4*i +: 4];
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
module tb_seven_segment_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic        lz = 1'b0;
  logic [3:0]  bcd_out;
  logic        seg_blank;
  logic [3:0]  digit_en;
  logic        frame_done;
`ifdef SEVEN_SEG_BLINK_EN
  logic [3:0]  blink_mask = '0;
`endif

  int cmp = 0;
  int bad = 0;
  int e = 0;              // rising edges since reset release
  logic [3:0] xb [4];     // expected bcd per digit
  bit         xv [4];     // expected visibility per digit

  always #5 clk = ~clk;

  seven_segment_scan_controller #(
    .NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2), .DIGIT_ACTIVE_LOW(1)
`ifdef SEVEN_SEG_BLINK_EN
    , .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .lz_suppress_en(lz),
`ifdef SEVEN_SEG_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .bcd_out(bcd_out), .seg_blank(seg_blank), .digit_en(digit_en), .frame_done(frame_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    e++;
  endtask

  // Position within the 24-cycle frame: 6 cycles per digit, 2 blank then 4 dwell.
  function automatic int fpos();
    return (e - 1) % 24;
  endfunction

  // Expected {digit_en, seg_blank, frame_done} at frame position k.
  function automatic logic [5:0] exp_v(int k);
    int s;
    logic [3:0] en;
    s = k / 6;
    en = ((k % 6) >= 2 && xv[s]) ? ~(4'b0001 << s) : 4'hF;
    return {en, ((k % 6) >= 2) ? !xv[s] : 1'b1, (k == 0 && e > 1)};
  endfunction

  task automatic wait_frame_start;
    for (int i = 0; i < 24; i++) begin
      tick;
      if (fpos() == 0) break;
    end
  endtask

  task automatic offer(input logic [15:0] w);
    load_valid = 1'b1;
    load_data  = w;
    tick;
    load_valid = 1'b0;
  endtask

  task automatic set_exp(input logic [15:0] w, input bit v0, v1, v2, v3);
    for (int i = 0; i < 4; i++) xb[i] = w[4*i +: 4];
    xv[0] = v0; xv[1] = v1; xv[2] = v2; xv[3] = v3;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    cmp++;
    if ({load_ready, bcd_out, seg_blank, digit_en, frame_done} !== {1'b1, 4'h0, 1'b1, 4'hF, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got rdy=%b bcd=%h sb=%b en=%b fd=%b want 1 0 1 1111 0",
               load_ready, bcd_out, seg_blank, digit_en, frame_done);
    end
    rst_n = 1'b1;
    e = 0;
    set_exp(16'h0000, 1, 1, 1, 1);
    for (int c = 0; c < 48; c++) begin
      tick;
      cmp++;
      if ({digit_en, seg_blank, frame_done} !== exp_v(fpos()) ||
          ((fpos() % 6) >= 2 && bcd_out !== xb[fpos() / 6])) begin
        bad++;
        $display("FAIL reset_scan e=%0d got en=%b sb=%b fd=%b bcd=%h want %b bcd=%h",
                 e, digit_en, seg_blank, frame_done, bcd_out, exp_v(fpos()), xb[fpos() / 6]);
      end
    end
  endtask

  task automatic test_load;
    while (fpos() != 10) tick;
    offer(16'h1234);
    cmp++;
    if (load_ready !== 1'b0) begin
      bad++;
      $display("FAIL load_ready_drop got %b want 0", load_ready);
    end
    for (int i = 0; i < 24 && fpos() != 0; i++) begin
      if ((fpos() % 6) >= 2) begin
        cmp++;
        if (bcd_out !== 4'h0) begin
          bad++;
          $display("FAIL load_no_tear e=%0d bcd got %h want 0", e, bcd_out);
        end
      end
      tick;
    end
    cmp++;
    if (load_ready !== 1'b1 || frame_done !== 1'b1) begin
      bad++;
      $display("FAIL load_commit got rdy=%b fd=%b want 1 1", load_ready, frame_done);
    end
    set_exp(16'h1234, 1, 1, 1, 1);
    for (int k = 0; k < 24; k++) begin
      cmp++;
      if ({digit_en, seg_blank, frame_done} !== exp_v(k) || ((k % 6) >= 2 && bcd_out !== xb[k / 6])) begin
        bad++;
        $display("FAIL load_frame k=%0d got en=%b sb=%b fd=%b bcd=%h want %b bcd=%h",
                 k, digit_en, seg_blank, frame_done, bcd_out, exp_v(k), xb[k / 6]);
      end
      tick;
    end
  endtask

  task automatic test_lz_invalid;
    lz = 1'b1;
    for (int t = 0; t < 3; t++) begin
      case (t)
        0: begin offer(16'h0050); set_exp(16'h0050, 1, 1, 0, 0); end
        1: begin offer(16'h00A7); set_exp(16'h00A7, 1, 0, 0, 0); end
        default: begin offer(16'h0000); set_exp(16'h0000, 1, 0, 0, 0); end
      endcase
      wait_frame_start;
      for (int k = 0; k < 24; k++) begin
        cmp++;
        if ({digit_en, seg_blank, frame_done} !== exp_v(k) || ((k % 6) >= 2 && bcd_out !== xb[k / 6])) begin
          bad++;
          $display("FAIL lz_invalid t=%0d k=%0d got en=%b sb=%b fd=%b bcd=%h want %b bcd=%h",
                   t, k, digit_en, seg_blank, frame_done, bcd_out, exp_v(k), xb[k / 6]);
        end
        tick;
      end
    end
    lz = 1'b0;
  endtask

  task automatic test_back_to_back;
    while (fpos() != 23) tick;
    offer(16'h5678);        // accepted on the wrap edge: must wait one more frame
    cmp++;
    if (load_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ready1 got %b want 0", load_ready);
    end
    offer(16'h9999);        // refused, shadow busy
    cmp++;
    if (load_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ready2 got %b want 0", load_ready);
    end
    for (int f = 0; f < 2; f++) begin
      if (f == 0) set_exp(16'h0000, 1, 1, 1, 1);
      else set_exp(16'h5678, 1, 1, 1, 1);
      for (int k = fpos(); k < 24; k++) begin
        cmp++;
        if ({digit_en, seg_blank, frame_done} !== exp_v(k) || ((k % 6) >= 2 && bcd_out !== xb[k / 6])) begin
          bad++;
          $display("FAIL b2b f=%0d k=%0d got en=%b sb=%b fd=%b bcd=%h want %b bcd=%h",
                   f, k, digit_en, seg_blank, frame_done, bcd_out, exp_v(k), xb[k / 6]);
        end
        tick;
      end
      cmp++;
      if (load_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_ready_after f=%0d got %b want 1", f, load_ready);
      end
    end
  endtask

  task automatic test_reset_mid;
    offer(16'h4321);
    while (fpos() != 3) tick;
    rst_n = 1'b0;
    #1;
    cmp++;
    if ({load_ready, bcd_out, seg_blank, digit_en, frame_done} !== {1'b1, 4'h0, 1'b1, 4'hF, 1'b0}) begin
      bad++;
      $display("FAIL reset_mid got rdy=%b bcd=%h sb=%b en=%b fd=%b want 1 0 1 1111 0",
               load_ready, bcd_out, seg_blank, digit_en, frame_done);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e = 0;
    set_exp(16'h0000, 1, 1, 1, 1);
    for (int c = 0; c < 48; c++) begin
      tick;
      cmp++;
      if ({digit_en, seg_blank, frame_done} !== exp_v(fpos()) ||
          ((fpos() % 6) >= 2 && bcd_out !== xb[fpos() / 6])) begin
        bad++;
        $display("FAIL reset_discard e=%0d got en=%b sb=%b fd=%b bcd=%h want %b bcd=%h",
                 e, digit_en, seg_blank, frame_done, bcd_out, exp_v(fpos()), xb[fpos() / 6]);
      end
    end
  endtask

`ifdef SEVEN_SEG_BLINK_EN
  task automatic test_blink;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    e = 0;
    tick;
    tick;
    blink_mask = 4'b0001;
    offer(16'h0000);
    blink_mask = 4'b0000;
    wait_frame_start;
    for (int f = 1; f <= 5; f++) begin
      set_exp(16'h0000, (f == 1 || f >= 4), 1, 1, 1);
      for (int k = 0; k < 24; k++) begin
        cmp++;
        if ({digit_en, seg_blank, frame_done} !== exp_v(k) || ((k % 6) >= 2 && bcd_out !== xb[k / 6])) begin
          bad++;
          $display("FAIL blink f=%0d k=%0d got en=%b sb=%b fd=%b want %b",
                   f, k, digit_en, seg_blank, frame_done, exp_v(k));
        end
        tick;
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_load;
    test_lz_invalid;
    test_back_to_back;
    test_reset_mid;
`ifdef SEVEN_SEG_BLINK_EN
    test_blink;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
